// File: rtl/pipe_ctrl.sv
// pipe_ctrl: ID decode, load-use stall, branch flush and operand forwarding control for a 5-stage in-order pipeline.
// Stage controls are registered (EX +1, MEM +2, WB +3 cycles); stall/flush/forward selects are combinational; the pipe never accepts backpressure.
module pipe_ctrl #(
   parameter int OPCODE_W = 7,
   parameter int REG_W    = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] id_opcode,
   input  logic [REG_W-1:0]    id_rs1,
   input  logic [REG_W-1:0]    id_rs2,
   input  logic [REG_W-1:0]    id_rd,
   input  logic                ex_branch_taken,
   output logic                pc_write,
   output logic                ifid_write,
   output logic                ifid_flush,
   output logic                ex_alusrc,
   output logic [1:0]          ex_aluop,
   output logic                ex_branch,
   output logic                mem_read,
   output logic                mem_write,
   output logic                wb_regwrite,
   output logic                wb_memtoreg,
   output logic [REG_W-1:0]    wb_rd,
   output logic [1:0]          fwd_a,
   output logic [1:0]          fwd_b,
   output logic [15:0]         stall_cnt
);

   localparam logic [OPCODE_W-1:0] OP_R     = OPCODE_W'(7'b0110011);
   localparam logic [OPCODE_W-1:0] OP_I     = OPCODE_W'(7'b0010011);
   localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(7'b0000011);
   localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(7'b0100011);
   localparam logic [OPCODE_W-1:0] OP_BR    = OPCODE_W'(7'b1100011);

   typedef struct packed {
      logic       alusrc;
      logic       memtoreg;
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       branch;
      logic [1:0] aluop;
   } ctrl_t;

   typedef struct packed {
      ctrl_t            ctrl;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
   } idex_t;

   typedef struct packed {
      logic             memtoreg;
      logic             regwrite;
      logic             memread;
      logic             memwrite;
      logic [REG_W-1:0] rd;
   } exmem_t;

   typedef struct packed {
      logic             memtoreg;
      logic             regwrite;
      logic [REG_W-1:0] rd;
   } memwb_t;

   ctrl_t   id_ctrl;
   logic    rs1_used;
   logic    rs2_used;
   idex_t   idex_q;
   idex_t   idex_d;
   exmem_t  exmem_q;
   memwb_t  memwb_q;
   logic    load_use;
   logic    br_flush;
   logic    stall;
   logic [15:0] stall_cnt_q;

   // Unknown opcodes decode to the all-zero bubble with no register reads.
   always_comb begin
      id_ctrl  = '0;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      case (id_opcode)
         OP_R: begin
            id_ctrl  = '{alusrc: 1'b0, memtoreg: 1'b0, regwrite: 1'b1, memread: 1'b0,
                         memwrite: 1'b0, branch: 1'b0, aluop: 2'b10};
            rs1_used = 1'b1;
            rs2_used = 1'b1;
         end
         OP_I: begin
            id_ctrl  = '{alusrc: 1'b1, memtoreg: 1'b0, regwrite: 1'b1, memread: 1'b0,
                         memwrite: 1'b0, branch: 1'b0, aluop: 2'b11};
            rs1_used = 1'b1;
         end
         OP_LOAD: begin
            id_ctrl  = '{alusrc: 1'b1, memtoreg: 1'b1, regwrite: 1'b1, memread: 1'b1,
                         memwrite: 1'b0, branch: 1'b0, aluop: 2'b00};
            rs1_used = 1'b1;
         end
         OP_STORE: begin
            id_ctrl  = '{alusrc: 1'b1, memtoreg: 1'b0, regwrite: 1'b0, memread: 1'b0,
                         memwrite: 1'b1, branch: 1'b0, aluop: 2'b00};
            rs1_used = 1'b1;
            rs2_used = 1'b1;
         end
         OP_BR: begin
            id_ctrl  = '{alusrc: 1'b0, memtoreg: 1'b0, regwrite: 1'b0, memread: 1'b0,
                         memwrite: 1'b0, branch: 1'b1, aluop: 2'b01};
            rs1_used = 1'b1;
            rs2_used = 1'b1;
         end
         default: ;
      endcase
   end

   // x0 is hardwired, so a load targeting it never creates a dependency.
   assign load_use = idex_q.ctrl.memread && (idex_q.rd != '0) &&
                     ((rs1_used && (idex_q.rd == id_rs1)) ||
                      (rs2_used && (idex_q.rd == id_rs2)));
   assign br_flush = idex_q.ctrl.branch && ex_branch_taken;
   assign stall    = load_use && !br_flush;

   assign pc_write   = !stall;
   assign ifid_write = !stall;
   assign ifid_flush = br_flush;

   always_comb begin
      idex_d = '0;
      if (!(load_use || br_flush)) begin
         idex_d.ctrl = id_ctrl;
         idex_d.rs1  = id_rs1;
         idex_d.rs2  = id_rs2;
         idex_d.rd   = id_rd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idex_q  <= '0;
         exmem_q <= '0;
         memwb_q <= '0;
      end else begin
         idex_q           <= idex_d;
         exmem_q.memtoreg <= idex_q.ctrl.memtoreg;
         exmem_q.regwrite <= idex_q.ctrl.regwrite;
         exmem_q.memread  <= idex_q.ctrl.memread;
         exmem_q.memwrite <= idex_q.ctrl.memwrite;
         exmem_q.rd       <= idex_q.rd;
         memwb_q.memtoreg <= exmem_q.memtoreg;
         memwb_q.regwrite <= exmem_q.regwrite;
         memwb_q.rd       <= exmem_q.rd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   // The younger result (EX/MEM) wins over MEM/WB when both target the same register.
   always_comb begin
      fwd_a = 2'b00;
      if (exmem_q.regwrite && (exmem_q.rd != '0) && (exmem_q.rd == idex_q.rs1)) begin
         fwd_a = 2'b10;
      end else if (memwb_q.regwrite && (memwb_q.rd != '0) && (memwb_q.rd == idex_q.rs1)) begin
         fwd_a = 2'b01;
      end
   end

   always_comb begin
      fwd_b = 2'b00;
      if (exmem_q.regwrite && (exmem_q.rd != '0) && (exmem_q.rd == idex_q.rs2)) begin
         fwd_b = 2'b10;
      end else if (memwb_q.regwrite && (memwb_q.rd != '0) && (memwb_q.rd == idex_q.rs2)) begin
         fwd_b = 2'b01;
      end
   end

   assign ex_alusrc   = idex_q.ctrl.alusrc;
   assign ex_aluop    = idex_q.ctrl.aluop;
   assign ex_branch   = idex_q.ctrl.branch;
   assign mem_read    = exmem_q.memread;
   assign mem_write   = exmem_q.memwrite;
   assign wb_regwrite = memwb_q.regwrite;
   assign wb_memtoreg = memwb_q.memtoreg;
   assign wb_rd       = memwb_q.rd;
   assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: instruction-level pipeline model feeds an expectation queue, a negedge monitor compares every output.
module tb_pipe_ctrl;

   localparam logic [6:0] R = 7'b0110011;
   localparam logic [6:0] I = 7'b0010011;
   localparam logic [6:0] L = 7'b0000011;
   localparam logic [6:0] S = 7'b0100011;
   localparam logic [6:0] B = 7'b1100011;
   localparam logic [6:0] X = 7'b1111111;
   localparam logic [6:0] N = 7'b0000000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  id_opcode = '0;
   logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic        ex_branch_taken = 1'b0;
   logic        pc_write, ifid_write, ifid_flush, ex_alusrc, ex_branch;
   logic        mem_read, mem_write, wb_regwrite, wb_memtoreg;
   logic [1:0]  ex_aluop, fwd_a, fwd_b;
   logic [4:0]  wb_rd;
   logic [15:0] stall_cnt;

   pipe_ctrl #(.OPCODE_W(7), .REG_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .ex_branch_taken(ex_branch_taken), .pc_write(pc_write),
      .ifid_write(ifid_write), .ifid_flush(ifid_flush), .ex_alusrc(ex_alusrc),
      .ex_aluop(ex_aluop), .ex_branch(ex_branch), .mem_read(mem_read), .mem_write(mem_write),
      .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] op;
      logic [4:0] rs1, rs2, rd;
   } instr_t;

   typedef struct {
      logic        pc_write, ifid_write, ifid_flush, ex_alusrc, ex_branch;
      logic        mem_read, mem_write, wb_regwrite, wb_memtoreg;
      logic [1:0]  ex_aluop, fwd_a, fwd_b;
      logic [4:0]  wb_rd;
      logic [15:0] stall_cnt;
   } exp_t;

   exp_t   q[$];
   instr_t m_ex, m_mem, m_wb;
   instr_t bub;
   int     m_cnt = 0;
   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;

   // {alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop[1:0]}
   function automatic logic [7:0] dec(input logic [6:0] op);
      case (op)
         R:       return 8'b0_0_1_0_0_0_10;
         I:       return 8'b1_0_1_0_0_0_11;
         L:       return 8'b1_1_1_1_0_0_00;
         S:       return 8'b1_0_0_0_1_0_00;
         B:       return 8'b0_0_0_0_0_1_01;
         default: return 8'b0;
      endcase
   endfunction

   function automatic bit reads_rs1(input logic [6:0] op);
      return (op == R) || (op == I) || (op == L) || (op == S) || (op == B);
   endfunction

   function automatic bit reads_rs2(input logic [6:0] op);
      return (op == R) || (op == S) || (op == B);
   endfunction

   function automatic logic [1:0] fwd_of(input logic [4:0] src);
      logic [7:0] dm, dw;
      dm = dec(m_mem.op);
      dw = dec(m_wb.op);
      if (dm[5] && m_mem.rd != 0 && m_mem.rd == src) return 2'b10;
      if (dw[5] && m_wb.rd != 0 && m_wb.rd == src) return 2'b01;
      return 2'b00;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, expv);
      end
   endtask

   // One clock of stimulus: drive ID inputs, predict this cycle's outputs, then advance the model.
   task automatic step(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic tk = 1'b0, input logic rst = 1'b0,
                       input logic frc = 1'b0);
      exp_t e;
      logic [7:0] de, dm, dw;
      bit haz, fl, stl;
      @(posedge clk);
      #1;
      cyc++;
      id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd; ex_branch_taken = tk;
      rst_n = ~rst;
      if (frc && !rst) force dut.load_use = 1'b1;
      else release dut.load_use;
      if (rst) begin
         m_ex = bub; m_mem = bub; m_wb = bub; m_cnt = 0;
      end
      de = dec(m_ex.op);
      dm = dec(m_mem.op);
      dw = dec(m_wb.op);
      haz = (frc && !rst) ||
            (de[4] && m_ex.rd != 0 &&
             ((m_ex.rd == r1 && reads_rs1(op)) || (m_ex.rd == r2 && reads_rs2(op))));
      fl  = de[2] && tk;
      stl = haz && !fl;
      e.pc_write    = !stl;
      e.ifid_write  = !stl;
      e.ifid_flush  = fl;
      e.ex_alusrc   = de[7];
      e.ex_aluop    = de[1:0];
      e.ex_branch   = de[2];
      e.mem_read    = dm[4];
      e.mem_write   = dm[3];
      e.wb_regwrite = dw[5];
      e.wb_memtoreg = dw[6];
      e.wb_rd       = m_wb.rd;
      e.fwd_a       = fwd_of(m_ex.rs1);
      e.fwd_b       = fwd_of(m_ex.rs2);
      e.stall_cnt   = 16'(m_cnt);
      q.push_back(e);
      if (!rst) begin
         m_wb  = m_mem;
         m_mem = m_ex;
         if (haz || fl) m_ex = bub;
         else begin
            m_ex.op = op; m_ex.rs1 = r1; m_ex.rs2 = r2; m_ex.rd = rd;
         end
         if (stl && m_cnt < 65535) m_cnt++;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc_write",    32'(pc_write),    32'(e.pc_write));
            chk("ifid_write",  32'(ifid_write),  32'(e.ifid_write));
            chk("ifid_flush",  32'(ifid_flush),  32'(e.ifid_flush));
            chk("ex_alusrc",   32'(ex_alusrc),   32'(e.ex_alusrc));
            chk("ex_aluop",    32'(ex_aluop),    32'(e.ex_aluop));
            chk("ex_branch",   32'(ex_branch),   32'(e.ex_branch));
            chk("mem_read",    32'(mem_read),    32'(e.mem_read));
            chk("mem_write",   32'(mem_write),   32'(e.mem_write));
            chk("wb_regwrite", 32'(wb_regwrite), 32'(e.wb_regwrite));
            chk("wb_memtoreg", 32'(wb_memtoreg), 32'(e.wb_memtoreg));
            chk("wb_rd",       32'(wb_rd),       32'(e.wb_rd));
            chk("fwd_a",       32'(fwd_a),       32'(e.fwd_a));
            chk("fwd_b",       32'(fwd_b),       32'(e.fwd_b));
            chk("stall_cnt",   32'(stall_cnt),   32'(e.stall_cnt));
         end
      end
   end

   initial begin : stimulus
      logic [6:0] ops [7];
      ops = '{R, I, L, S, B, X, N};
      bub = '{op: N, rs1: 0, rs2: 0, rd: 0};
      m_ex = bub; m_mem = bub; m_wb = bub;

      step(N, 0, 0, 0, 0, 1);
      step(N, 0, 0, 0, 0, 1);

      // each opcode followed by bubbles so EX, MEM and WB are seen in isolation
      step(R, 1, 2, 3);  step(N, 0, 0, 0); step(N, 0, 0, 0); step(N, 0, 0, 0);
      step(I, 1, 2, 4);  step(N, 0, 0, 0); step(N, 0, 0, 0); step(N, 0, 0, 0);
      step(L, 1, 2, 5);  step(N, 0, 0, 0); step(N, 0, 0, 0); step(N, 0, 0, 0);
      step(S, 1, 2, 6);  step(N, 0, 0, 0); step(N, 0, 0, 0); step(N, 0, 0, 0);
      step(B, 1, 2, 7);  step(N, 0, 0, 0); step(N, 0, 0, 0); step(N, 0, 0, 0);
      step(X, 1, 2, 0);  step(N, 0, 0, 0); step(N, 0, 0, 0); step(N, 0, 0, 0);

      // ld x5 ; add x6,x5,x7 held in ID across the stall
      step(L, 1, 0, 5);  step(R, 5, 7, 6); step(R, 5, 7, 6); step(N, 0, 0, 0);
      step(N, 0, 0, 0);  step(N, 0, 0, 0);

      // x0 destination and unused rs2 never stall
      step(L, 1, 0, 0);  step(R, 0, 0, 6); step(N, 0, 0, 0); step(N, 0, 0, 0);
      step(L, 1, 0, 5);  step(I, 9, 5, 6); step(N, 0, 0, 0); step(N, 0, 0, 0);

      // back-to-back producer/consumer, then EX/MEM vs MEM/WB tie on x3
      step(R, 1, 2, 3);  step(R, 3, 3, 4); step(N, 0, 0, 0); step(N, 0, 0, 0);
      step(R, 1, 2, 3);  step(R, 1, 2, 3); step(R, 3, 3, 8); step(N, 0, 0, 0);
      step(N, 0, 0, 0);  step(N, 0, 0, 0);

      // taken branch in EX overrides a hazard on the instruction in ID
      step(B, 1, 2, 0);  step(R, 5, 7, 6, 1, 0, 1); step(N, 0, 0, 0); step(N, 0, 0, 0);

      // reset pulse landing on a live load-use stall
      step(L, 1, 0, 5);  step(R, 5, 7, 6, 0, 1); step(R, 5, 7, 6); step(N, 0, 0, 0);

      for (int i = 0; i < 3000; i++) begin
         step(ops[$urandom_range(0, 6)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end

      // long stall streak to drive the counter into saturation
      for (int i = 0; i < 65536; i++) begin
         step(ops[$urandom_range(0, 6)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 0, 0, 1);
      end
      step(R, 5, 7, 6, 0, 0, 1);
      step(R, 5, 7, 6, 0, 1, 1);
      step(N, 0, 0, 0);
      step(L, 1, 0, 5);  step(R, 5, 7, 6); step(R, 5, 7, 6); step(N, 0, 0, 0);

      @(negedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
